// File: rtl/snake_body_walker.sv
// Walks the recirculating snake body from tail to head, tracking a cursor and
// flagging a query-cell collision. Optional macro: SNAKE_WRAP_EN (grid-bound wrap).
module snake_body_walker #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned DEPTH  = 234,
  parameter int unsigned GRID_W = 18,
  parameter int unsigned GRID_H = 13,
  parameter int unsigned X_W    = 5,
  parameter int unsigned Y_W    = 4,
  parameter int unsigned LEN_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [X_W-1:0]   tail_x,
  input  logic [Y_W-1:0]   tail_y,
  input  logic [LEN_W-1:0] length,
  input  logic [X_W-1:0]   query_x,
  input  logic [Y_W-1:0]   query_y,
  input  logic [WIDTH-1:0] seg_dir,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [X_W-1:0]   end_x,
  output logic [Y_W-1:0]   end_y
);

  localparam int unsigned CNT_W = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] DIR_PX = WIDTH'(0);
  localparam logic [WIDTH-1:0] DIR_PY = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIR_NX = WIDTH'(2);
  localparam logic [WIDTH-1:0] DIR_NY = WIDTH'(3);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_WALK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   skip_q, skip_d;
  logic [X_W-1:0]     cur_x_q, cur_x_d, qx_q, qx_d, end_x_d, nxt_x;
  logic [Y_W-1:0]     cur_y_q, cur_y_d, qy_q, qy_d, end_y_d, nxt_y;
  logic               hit_d, busy_d, shift_d, done_d;
  logic [31:0]        len_eff;

  // One cursor step along x or y for a direction code
  function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x, input logic [WIDTH-1:0] d);
    logic [X_W-1:0] r;
    r = x;
`ifdef SNAKE_WRAP_EN
    if (d == DIR_PX)      r = (x == X_W'(GRID_W - 1)) ? '0 : x + 1'b1;
    else if (d == DIR_NX) r = (x == '0) ? X_W'(GRID_W - 1) : x - 1'b1;
`else
    if (d == DIR_PX)      r = x + 1'b1;
    else if (d == DIR_NX) r = x - 1'b1;
`endif
    return r;
  endfunction

  function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] y, input logic [WIDTH-1:0] d);
    logic [Y_W-1:0] r;
    r = y;
`ifdef SNAKE_WRAP_EN
    if (d == DIR_PY)      r = (y == Y_W'(GRID_H - 1)) ? '0 : y + 1'b1;
    else if (d == DIR_NY) r = (y == '0) ? Y_W'(GRID_H - 1) : y - 1'b1;
`else
    if (d == DIR_PY)      r = y + 1'b1;
    else if (d == DIR_NY) r = y - 1'b1;
`endif
    return r;
  endfunction

  assign nxt_x   = step_x(cur_x_q, seg_dir);
  assign nxt_y   = step_y(cur_y_q, seg_dir);
  assign len_eff = (32'(length) >= DEPTH) ? DEPTH : 32'(length);

  // Next-state and registered-output logic; outputs reflect the upcoming state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    hit_d   = hit;
    end_x_d = end_x;
    end_y_d = end_y;
    busy_d  = 1'b0;
    shift_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          skip_d  = CNT_W'(DEPTH - len_eff);
          cur_x_d = tail_x;
          cur_y_d = tail_y;
          qx_d    = query_x;
          qy_d    = query_y;
          hit_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          shift_d = 1'b1;
          state_d = (len_eff < DEPTH) ? S_SKIP : S_WALK;
        end
      end
      S_SKIP: begin
        cnt_d = cnt_q + 1'b1;
        // An empty body skips every slot and finishes straight from here
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          end_x_d = cur_x_q;
          end_y_d = cur_y_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d  = 1'b1;
          shift_d = 1'b1;
          if (cnt_q == skip_q - 1'b1) state_d = S_WALK;
        end
      end
      S_WALK: begin
        cnt_d   = cnt_q + 1'b1;
        cur_x_d = nxt_x;
        cur_y_d = nxt_y;
        if (cur_x_q == qx_q && cur_y_q == qy_q) hit_d = 1'b1;
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          end_x_d = nxt_x;
          end_y_d = nxt_y;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d  = 1'b1;
          shift_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      skip_q   <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      qx_q     <= '0;
      qy_q     <= '0;
      hit      <= 1'b0;
      end_x    <= '0;
      end_y    <= '0;
      busy     <= 1'b0;
      shift_en <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      skip_q   <= skip_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      qx_q     <= qx_d;
      qy_q     <= qy_d;
      hit      <= hit_d;
      end_x    <= end_x_d;
      end_y    <= end_y_d;
      busy     <= busy_d;
      shift_en <= shift_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_snake_body_walker.sv
// Bench for snake_body_walker: recirculating shift-register model, coordinate
// model of the body walk, per-cycle timing checks and literal expectations.
module tb_snake_body_walker;
  localparam int unsigned WIDTH  = 2;
  localparam int unsigned DEPTH  = 234;
  localparam int unsigned GRID_W = 18;
  localparam int unsigned GRID_H = 13;
  localparam int unsigned X_W    = 5;
  localparam int unsigned Y_W    = 4;
  localparam int unsigned LEN_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [X_W-1:0]   tail_x = '0, query_x = '0;
  logic [Y_W-1:0]   tail_y = '0, query_y = '0;
  logic [LEN_W-1:0] length = '0;
  logic [WIDTH-1:0] seg_dir;
  logic             shift_en, busy, done, hit;
  logic [X_W-1:0]   end_x;
  logic [Y_W-1:0]   end_y;

  snake_body_walker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .GRID_W(GRID_W), .GRID_H(GRID_H),
    .X_W(X_W), .Y_W(Y_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .tail_x(tail_x), .tail_y(tail_y), .length(length),
    .query_x(query_x), .query_y(query_y), .seg_dir(seg_dir),
    .shift_en(shift_en), .busy(busy), .done(done), .hit(hit),
    .end_x(end_x), .end_y(end_y)
  );

  always #5 clk = ~clk;

  // Rotating register: slot i (0 = oldest) lives at physical index (ptr+i)%DEPTH
  logic [WIDTH-1:0] sr [DEPTH];
  int ptr = 0;
  int cyc = 0;
  assign seg_dir = sr[ptr];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (shift_en) ptr <= (ptr + 1) % DEPTH;
  end

  int total = 0;
  int bad = 0;
  int exp_hit = 0, exp_ex = 0, exp_ey = 0;
  int t0 = 0;
  int ck = 0;
  bit armed = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic fill(input int c);
    for (int i = 0; i < DEPTH; i++) sr[i] = WIDTH'(c);
  endtask

  task automatic set_slot(input int i, input int c);
    sr[(ptr + i) % DEPTH] = WIDTH'(c);
  endtask

  function automatic int wrapm(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  // Visit each valid body cell from the tail, then compute the head
  task automatic model(input int tx, input int ty, input int len, input int qx, input int qy);
    int le, x, y, mx, my, h, code;
    le = (len > DEPTH) ? DEPTH : len;
`ifdef SNAKE_WRAP_EN
    mx = GRID_W; my = GRID_H;
`else
    mx = 1 << X_W; my = 1 << Y_W;
`endif
    x = tx; y = ty; h = 0;
    for (int i = DEPTH - le; i < DEPTH; i++) begin
      code = int'(sr[(ptr + i) % DEPTH]);
      if (x == qx && y == qy) h = 1;
      case (code)
        0: x = wrapm(x + 1, mx);
        1: y = wrapm(y + 1, my);
        2: x = wrapm(x - 1, mx);
        default: y = wrapm(y - 1, my);
      endcase
    end
    exp_hit = h; exp_ex = x; exp_ey = y;
  endtask

  // Timeline checks relative to the accepting edge (k=1 is the first busy cycle)
  always @(posedge clk) begin
    #1;
    if (armed) begin
      ck = cyc - t0 + 1;
      if (ck >= 1 && ck <= DEPTH) begin
        check("busy_in_walk", int'(busy), 1);
        check("shift_in_walk", int'(shift_en), 1);
        check("done_in_walk", int'(done), 0);
      end else if (ck == DEPTH + 1) begin
        check("done_pulse", int'(done), 1);
        check("busy_at_done", int'(busy), 0);
        check("shift_at_done", int'(shift_en), 0);
        check("hit_at_done", int'(hit), exp_hit);
        check("end_x_at_done", int'(end_x), exp_ex);
        check("end_y_at_done", int'(end_y), exp_ey);
      end else if (ck > DEPTH + 1) begin
        check("done_after", int'(done), 0);
        check("busy_after", int'(busy), 0);
        check("shift_after", int'(shift_en), 0);
        check("hit_hold", int'(hit), exp_hit);
        check("end_x_hold", int'(end_x), exp_ex);
        check("end_y_hold", int'(end_y), exp_ey);
      end
    end
  end

  // Returns at the negedge of the DONE cycle
  task automatic run(input int tx, input int ty, input int len, input int qx, input int qy,
                     input bit poke);
    @(negedge clk);
    model(tx, ty, len, qx, qy);
    tail_x = X_W'(tx); tail_y = Y_W'(ty); length = LEN_W'(len);
    query_x = X_W'(qx); query_y = Y_W'(qy);
    start = 1'b1;
    t0 = cyc + 1;
    armed = 1'b1;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      @(negedge clk);
      if (poke && (k == 10 || k == DEPTH + 1)) begin
        start = 1'b1;
        tail_x = X_W'(1); tail_y = Y_W'(1); length = LEN_W'(3);
        query_x = X_W'(1); query_y = Y_W'(1);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic load_straight();
    fill(1);
    for (int i = DEPTH - 4; i < DEPTH; i++) set_slot(i, 0);
  endtask

  initial begin
    fill(0);
    repeat (3) @(negedge clk);
    check("rst_shift_en", int'(shift_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_end_x", int'(end_x), 0);
    check("rst_end_y", int'(end_y), 0);
    rst_n = 1'b1;

    // Straight body with ignored starts mid-walk and in the DONE cycle
    load_straight();
    run(2, 5, 4, 4, 5, 1'b1);
    check("straight_hit", int'(hit), 1);
    check("straight_end_x", int'(end_x), 6);
    check("straight_end_y", int'(end_y), 5);

    load_straight();
    run(2, 5, 4, 6, 5, 1'b0);
    check("head_query_hit", int'(hit), 0);
    check("head_query_end_x", int'(end_x), 6);
    check("head_query_end_y", int'(end_y), 5);

    for (int i = 0; i < DEPTH; i++) sr[i] = WIDTH'($urandom_range(0, 3));
    run(3, 3, 0, 3, 3, 1'b0);
    check("len0_hit", int'(hit), 0);
    check("len0_end_x", int'(end_x), 3);
    check("len0_end_y", int'(end_y), 3);

    fill(1);
    run(0, 0, 250, 0, 5, 1'b0);
    check("clamp_hit", int'(hit), 1);
    check("clamp_end_x", int'(end_x), 0);
`ifdef SNAKE_WRAP_EN
    check("clamp_end_y", int'(end_y), 0);
`else
    check("clamp_end_y", int'(end_y), 10);
`endif

    fill(2);
    set_slot(DEPTH - 2, 0);
    set_slot(DEPTH - 1, 3);
    run(17, 0, 2, 0, 0, 1'b0);
`ifdef SNAKE_WRAP_EN
    check("edge_hit", int'(hit), 1);
    check("edge_end_x", int'(end_x), 0);
    check("edge_end_y", int'(end_y), 12);
`else
    check("edge_hit", int'(hit), 0);
    check("edge_end_x", int'(end_x), 18);
    check("edge_end_y", int'(end_y), 15);
`endif

    for (int i = 0; i < DEPTH; i++) sr[i] = WIDTH'($urandom_range(0, 3));
    run(5, 6, 100, 5, 6, 1'b0);
    check("rand_tail_query_hit", int'(hit), 1);
    run(9, 2, 233, 4, 4, 1'b0);
    run(7, 7, 1, 7, 7, 1'b0);
    check("len1_hit", int'(hit), 1);

    // Reset mid-walk after the hit flag has been set
    fill(1);
    @(negedge clk);
    armed = 1'b0;
    tail_x = '0; tail_y = '0; length = LEN_W'(250);
    query_x = '0; query_y = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (48) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    check("pre_reset_hit", int'(hit), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_shift_en", int'(shift_en), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_hit", int'(hit), 0);
    check("midrst_end_x", int'(end_x), 0);
    check("midrst_end_y", int'(end_y), 0);
    @(negedge clk);
    rst_n = 1'b1;

    load_straight();
    run(2, 5, 4, 4, 5, 1'b0);
    check("post_rst_hit", int'(hit), 1);
    check("post_rst_end_x", int'(end_x), 6);
    check("post_rst_end_y", int'(end_y), 5);

    repeat (5) @(negedge clk);
    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snake_body_walker.md
# snake_body_walker

Streams the recirculating snake body out of the segment shift register, one direction code per shift. It reconstructs the occupied grid cells from the tail towards the head and reports whether a query cell (normally the proposed new head) collides with the body. It sits directly downstream of the segment shift register. It owns that register's shift enable; integration feeds `out` back to `in` during a walk so that the register returns to its original alignment after DEPTH shifts.

## Interface
- `WIDTH`, 2, bits per direction code: 0 = +x, 1 = +y, 2 = −x, 3 = −y.
- `DEPTH`, 234, segment slots in the shift register.
- `GRID_W`, 18, grid columns.
- `GRID_H`, 13, grid rows.
- `X_W`, 5, x coordinate width.
- `Y_W`, 4, y coordinate width.
- `LEN_W`, 8, length width.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request; honoured only while idle.
- `tail_x` in X_W, `tail_y` in Y_W: coordinate of the oldest valid segment; sampled on `start`.
- `length` in LEN_W: number of valid segments; sampled on `start`.
- `query_x` in X_W, `query_y` in Y_W: cell to test; sampled on `start`.
- `seg_dir` in WIDTH: shift register `out`, i.e. the oldest slot.
- `shift_en` out 1: shift register advances on the edge ending any cycle where this is 1.
- `busy` out 1: walk in progress.
- `done` out 1: one-cycle pulse when results become valid.
- `hit` out 1: query cell equals at least one valid body cell.
- `end_x` out X_W, `end_y` out Y_W: cursor position after the last valid segment, i.e. the head.

## Operation
- State machine IDLE → SKIP → WALK → DONE → IDLE. A slot counter `cnt` runs 0..DEPTH-1 across SKIP and WALK.
- IDLE: `start`=1 latches the inputs.
  - `len_eff` = min(length, DEPTH).
  - Cursor is set to (tail_x, tail_y).
  - `hit` is cleared and `cnt` is set to 0.
  - Next state is SKIP if `len_eff` < DEPTH, else WALK.
- SKIP: covers slots 0..DEPTH-len_eff-1, which hold stale segments. `shift_en`=1. The cursor and `hit` are untouched. Move to WALK after slot DEPTH-len_eff-1.
- WALK: covers slots DEPTH-len_eff..DEPTH-1, streamed oldest to newest. `shift_en`=1.
  - Each cycle, if cursor == query, set `hit` (sticky).
  - Then step the cursor by `seg_dir`.
  - Move to DONE after slot DEPTH-1.
- DONE: `shift_en`=0. `done`=1 for one cycle. `end_x`/`end_y` take the cursor value. Return to IDLE.
- The cell after the final step (the head) is never compared against the query.
- `length`=0: SKIP runs all DEPTH slots, `hit`=0, end equals tail.
- `length` > DEPTH: clamped to DEPTH, so SKIP is bypassed.
- `start` while busy is ignored. `start` in the DONE cycle is ignored.
- Cursor arithmetic per axis is modular; see Configuration.

## Timing
- Reset values: `shift_en`=0, `busy`=0, `done`=0, `hit`=0, `end_x`=0, `end_y`=0, state IDLE.
- `start` at edge T0:
  - `busy`=1 and `shift_en`=1 for exactly DEPTH cycles, T0+1..T0+DEPTH.
  - `done`=1 in cycle T0+DEPTH+1, then `busy`=0.
  - Start-to-done latency is DEPTH+1 cycles.
- `seg_dir` is sampled on the same edge that shifts the register.
- `hit`, `end_x` and `end_y` hold from `done` until the next accepted `start`.
- Earliest next `start` is the cycle after `done` (back-to-back period DEPTH+2).
- Asynchronous reset mid-walk drops `shift_en` immediately. Register alignment is then undefined, and the game FSM must reinitialise the body.

## Configuration
- `SNAKE_WRAP_EN` defined: the cursor wraps at grid bounds.
  - +x from GRID_W-1 → 0; −x from 0 → GRID_W-1.
  - Same on y with GRID_H.
  - Uses an explicit compare, with no modulo operator.
- Undefined: the cursor wraps modulo 2^X_W and 2^Y_W, with plain X_W/Y_W-bit add and subtract.

## Test plan
- Straight body: tail (2,5), length 4, newest four slots all code 0, query (4,5) → `hit`=1, end (6,5), `done` exactly 235 cycles after `start`.
- Same body, query (6,5) (the head) → `hit`=0, end (6,5).
- length 0, tail (3,3), query (3,3) → `hit`=0, end (3,3), `shift_en` high for 234 cycles.
- length 250 with all 234 slots code 1 and tail (0,0):
  - With `SNAKE_WRAP_EN` → end_y = 234 mod 13 = 0, end (0,0).
  - Without → end_y = 234 mod 16 = 10, end (0,10).
- Wrap edge, `SNAKE_WRAP_EN`: tail (17,0), length 2, codes 0,3 → end (0,12). Query (0,0) → `hit`=1.
- `start` pulsed at cycles T0+10 and T0+235 (the DONE cycle) are ignored. Reset asserted mid-walk → all outputs 0 in the same cycle. After release, a fresh `start` completes normally.
